// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: mult/div occupancy state encoding, the hardwired-zero register
//          number and the default mult/div latencies.
// Ports:   none (package).
package pipe_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         MULT_LAT_DEF = 4;
    localparam int         DIV_LAT_DEF  = 32;

endpackage

// File: rtl/md_occupancy.sv
// rtl/md_occupancy.sv - mult/div unit occupancy sequencer
//
// Purpose: tracks how long the iterative mult/div unit stays busy after a
//          start pulse and emits a one-cycle done pulse after the last busy cycle.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   MdStart_EX     start pulse (ignored while busy)
//   MdIsDiv_EX     1 = divide latency, 0 = multiply latency
//   md_busy        unit occupied
//   md_done        one-cycle pulse after the last busy cycle
module md_occupancy
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic MdStart_EX,
    input  logic MdIsDiv_EX,
    output logic md_busy,
    output logic md_done
);

    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    md_state_t     r_state;
    md_state_t     w_state_nxt;
    logic [CW-1:0] r_md_cnt;
    logic [CW-1:0] w_md_cnt_nxt;
    logic          r_md_done;
    logic          w_md_done_nxt;

    // State register: reset aborts a busy period with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= MD_IDLE;
            r_md_cnt  <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_md_cnt  <= w_md_cnt_nxt;
            r_md_done <= w_md_done_nxt;
        end
    end

    // Next-state logic: md_cnt holds remaining busy cycles minus one.
    always_comb begin
        w_state_nxt   = r_state;
        w_md_cnt_nxt  = r_md_cnt;
        w_md_done_nxt = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (MdStart_EX) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = MdIsDiv_EX ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt == '0) begin
                    w_state_nxt   = MD_IDLE;
                    w_md_done_nxt = 1'b1;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        md_busy = (r_state == MD_BUSY);
        md_done = r_md_done;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage MIPS core
//
// Purpose: detects load-use, mult/div structural and redirect hazards and
//          drives PC / IF/ID hold and IF/ID / ID/EX flush controls; keeps
//          saturating stall and flush statistics.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   MemRead_EX, rt_EX                   load in EX and its destination
//   rs_ID, rt_ID, UsesRt_ID             source operands of the ID instruction
//   BranchTaken_EX, Jump_ID             redirect sources
//   MdStart_EX, MdIsDiv_EX, MdUse_ID    mult/div start and ID-stage use
//   hold_PC, hold_IFID                  hold controls
//   flush_IFID, flush_IDEX              bubble-insertion controls
//   md_busy, md_done                    mult/div occupancy status
//   stall_cnt, flush_cnt                saturating statistics counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       rt_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             UsesRt_ID,
    input  logic             BranchTaken_EX,
    input  logic             Jump_ID,
    input  logic             MdStart_EX,
    input  logic             MdIsDiv_EX,
    input  logic             MdUse_ID,
    output logic             hold_PC,
    output logic             hold_IFID,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             w_md_busy;
    logic             w_lu;
    logic             w_ms;
    logic             w_stall;
    logic             w_flush;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    md_occupancy #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_occupancy (
        .clk        (clk),
        .reset      (reset),
        .MdStart_EX (MdStart_EX),
        .MdIsDiv_EX (MdIsDiv_EX),
        .md_busy    (w_md_busy),
        .md_done    (md_done)
    );

    assign md_busy = w_md_busy;

    // Load-use: $zero never carries a real dependency.
    assign w_lu = MemRead_EX && (rt_EX != REG_ZERO) &&
                  ((rt_EX == rs_ID) || (UsesRt_ID && (rt_EX == rt_ID)));

    // Structural: the start cycle itself counts, since the unit is claimed
    // at the next edge.
    assign w_ms = MdUse_ID && (w_md_busy || MdStart_EX);

    // Priority resolution. A taken branch wins over everything because the
    // ID instruction is wrong-path; ID/EX has no hold so stalls inject a bubble.
    always_comb begin
        hold_PC    = 1'b0;
        hold_IFID  = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        w_stall    = 1'b0;
        w_flush    = 1'b0;
        if (reset) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
        end else if (BranchTaken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            w_flush    = 1'b1;
        end else if (w_lu || w_ms) begin
            hold_PC    = 1'b1;
            hold_IFID  = 1'b1;
            flush_IDEX = 1'b1;
            w_stall    = 1'b1;
        end else if (Jump_ID) begin
            flush_IFID = 1'b1;
            w_flush    = 1'b1;
        end
    end

    // Saturating statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             MemRead_EX;
    logic [4:0]       rt_EX;
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             UsesRt_ID;
    logic             BranchTaken_EX;
    logic             Jump_ID;
    logic             MdStart_EX;
    logic             MdIsDiv_EX;
    logic             MdUse_ID;
    logic             hold_PC;
    logic             hold_IFID;
    logic             flush_IFID;
    logic             flush_IDEX;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .MULT_LAT (4),
        .DIV_LAT  (32),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead_EX     (MemRead_EX),
        .rt_EX          (rt_EX),
        .rs_ID          (rs_ID),
        .rt_ID          (rt_ID),
        .UsesRt_ID      (UsesRt_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .Jump_ID        (Jump_ID),
        .MdStart_EX     (MdStart_EX),
        .MdIsDiv_EX     (MdIsDiv_EX),
        .MdUse_ID       (MdUse_ID),
        .hold_PC        (hold_PC),
        .hold_IFID      (hold_IFID),
        .flush_IFID     (flush_IFID),
        .flush_IDEX     (flush_IDEX),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // controls packed as {hold_PC, hold_IFID, flush_IFID, flush_IDEX}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, hold_PC, hold_IFID, flush_IFID, flush_IDEX}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_EX = 0; rt_EX = 0; rs_ID = 0; rt_ID = 0; UsesRt_ID = 0;
        BranchTaken_EX = 0; Jump_ID = 0; MdStart_EX = 0; MdIsDiv_EX = 0; MdUse_ID = 0;
    endtask

    initial begin : main
        int n;
        bit seen_done;

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        chk_ctl("reset_ctl", 4'b0011);
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_done", {31'd0, md_done}, 32'd0);
        chk("reset_stall", {28'd0, stall_cnt}, 32'd0);
        chk("reset_flush", {28'd0, flush_cnt}, 32'd0);
        reset = 1'b0;
        #1;
        chk_ctl("idle_ctl", 4'b0000);

        // Load-use on rs
        tick();
        MemRead_EX = 1; rt_EX = 5'd8; rs_ID = 5'd8; #1;
        chk_ctl("lu_rs_ctl", 4'b1101);
        tick();
        chk("lu_rs_cnt", {28'd0, stall_cnt}, 32'd1);

        // rt_EX = $zero never stalls
        rt_EX = 5'd0; rs_ID = 5'd0; #1;
        chk_ctl("lu_zero_ctl", 4'b0000);
        tick();
        chk("lu_zero_cnt", {28'd0, stall_cnt}, 32'd1);

        // UsesRt gating
        rt_EX = 5'd9; rt_ID = 5'd9; rs_ID = 5'd3; UsesRt_ID = 1; #1;
        chk_ctl("usesrt1_ctl", 4'b1101);
        tick();
        UsesRt_ID = 0; #1;
        chk_ctl("usesrt0_ctl", 4'b0000);
        tick();
        chk("usesrt_cnt", {28'd0, stall_cnt}, 32'd2);
        idle_inputs();

        // Mult occupancy: start cycle plus four busy cycles stall
        MdStart_EX = 1; MdIsDiv_EX = 0; MdUse_ID = 1; #1;
        chk("mult_t0_busy", {31'd0, md_busy}, 32'd0);
        chk_ctl("mult_t0_ctl", 4'b1101);
        tick();
        MdStart_EX = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("mult_t%0d_busy", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("mult_t%0d_done", k), {31'd0, md_done}, 32'd0);
            chk_ctl($sformatf("mult_t%0d_ctl", k), 4'b1101);
            tick();
        end
        #1;
        chk("mult_t5_busy", {31'd0, md_busy}, 32'd0);
        chk("mult_t5_done", {31'd0, md_done}, 32'd1);
        chk_ctl("mult_t5_ctl", 4'b0000);
        chk("mult_stall_cnt", {28'd0, stall_cnt}, 32'd7);
        tick();
        chk("mult_t6_done", {31'd0, md_done}, 32'd0);
        idle_inputs();

        // Priority: branch beats load-use and jump
        MemRead_EX = 1; rt_EX = 5'd8; rs_ID = 5'd8; BranchTaken_EX = 1; Jump_ID = 1; #1;
        chk_ctl("br_prio_ctl", 4'b0011);
        tick();
        chk("br_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        chk("br_stall_cnt", {28'd0, stall_cnt}, 32'd7);
        idle_inputs();
        Jump_ID = 1; #1;
        chk_ctl("jump_ctl", 4'b0010);
        tick();
        chk("jump_flush_cnt", {28'd0, flush_cnt}, 32'd2);
        MemRead_EX = 1; rt_EX = 5'd8; rs_ID = 5'd8; #1;
        chk_ctl("lu_jump_ctl", 4'b1101);
        tick();
        chk("lu_jump_stall", {28'd0, stall_cnt}, 32'd8);
        chk("lu_jump_flush", {28'd0, flush_cnt}, 32'd2);
        idle_inputs();

        // Divide: exactly 32 busy cycles, then done
        MdStart_EX = 1; MdIsDiv_EX = 1; #1;
        tick();
        MdStart_EX = 0; MdIsDiv_EX = 0;
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            tick();
        end
        chk("div_busy_len", n, 32'd32);
        chk("div_done", {31'd0, md_done}, 32'd1);
        tick();

        // Reset in busy cycle 5 aborts with no done pulse
        MdStart_EX = 1; MdIsDiv_EX = 1; #1;
        tick();
        MdStart_EX = 0; MdIsDiv_EX = 0;
        for (int k = 1; k < 5; k++) tick();
        chk("div_busy_c5", {31'd0, md_busy}, 32'd1);
        reset = 1'b1; #1;
        chk("abort_busy", {31'd0, md_busy}, 32'd0);
        chk_ctl("abort_ctl", 4'b0011);
        tick();
        reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (md_done || md_busy) seen_done = 1;
            tick();
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        chk("abort_stall_clr", {28'd0, stall_cnt}, 32'd0);

        // Saturation: 20 stall cycles on a 4-bit counter
        MemRead_EX = 1; rt_EX = 5'd8; rs_ID = 5'd8;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_stall", {28'd0, stall_cnt}, 32'd15);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
